// File: rtl/tt_sweep_checker.sv
// tt_sweep_checker
//
// Purpose: drives all 16 input vectors into a 4-input circuit under test,
// holds each vector for SETTLE_CYCLES, then samples the circuit's output
// for one cycle. The 16 samples form a truth table, which is compared
// against EXPECTED_TT at the end of the sweep.
//
// Build option: defining TT_SWEEP_STABLE_CHECK_EN adds a stability check.
// out_s is registered in the last settle cycle and compared with out_s at
// sample time. Without the macro, unstable_mask is tied to zero.
//
// Ports:
//   clk            clock, rising edge
//   rst_n          asynchronous active-low reset
//   start          one-cycle sweep request (honoured only in IDLE)
//   abort          cancels an active sweep (no done pulse)
//   out_s          circuit output, already synchronous to clk
//   in1..in4       registered stimulus, vector index i = {in1,in2,in3,in4}
//   busy           high while a sweep is running
//   done           one-cycle pulse at the end of a completed sweep
//   pass           captured table matched (and was stable); held until next start
//   tt_captured    captured truth table, unsampled bits read 0
//   mismatch_mask  tt_captured ^ EXPECTED_TT, valid from done
//   unstable_mask  vectors whose output changed between last settle and sample
//
// States:
//   IDLE   | waiting for start, stimulus parked at 0
//   SETTLE | vector held, counter running down from SETTLE_CYCLES
//   SAMPLE | out_s captured into tt_captured[idx]
//   DONE   | one-cycle result cycle, done=1, then back to IDLE
module tt_sweep_checker #(
  parameter logic [15:0] EXPECTED_TT   = 16'h2FC7,
  parameter int unsigned SETTLE_CYCLES = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        abort,
  input  logic        out_s,
  output logic        in1,
  output logic        in2,
  output logic        in3,
  output logic        in4,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [15:0] tt_captured,
  output logic [15:0] mismatch_mask,
  output logic [15:0] unstable_mask
);

  typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, DONE} state_t;

  localparam logic [7:0] SETTLE_LOAD = 8'(SETTLE_CYCLES);

  state_t      state_q;
  logic [3:0]  idx_q;
  logic [7:0]  cnt_q;
  logic [3:0]  vec_q;
  logic        busy_q;
  logic        done_q;
  logic        pass_q;
  logic [15:0] tt_q;
  logic [15:0] mm_q;
  logic [15:0] tt_d;
  logic [15:0] um_d;

`ifdef TT_SWEEP_STABLE_CHECK_EN
  logic        stab_q;
  logic [15:0] um_q;
`endif

  // Table contents as they will be after the current SAMPLE cycle; used so
  // the final compare in the SAMPLE->DONE step sees bit 15 as well.
  always_comb begin
    tt_d        = tt_q;
    tt_d[idx_q] = out_s;
`ifdef TT_SWEEP_STABLE_CHECK_EN
    um_d        = um_q;
    um_d[idx_q] = stab_q ^ out_s;
`else
    um_d        = '0;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      vec_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      tt_q    <= '0;
      mm_q    <= '0;
`ifdef TT_SWEEP_STABLE_CHECK_EN
      stab_q  <= 1'b0;
      um_q    <= '0;
`endif
    end else begin
      done_q <= 1'b0;
      // abort wins over every transition, including the final sample
      if (abort && (state_q != IDLE)) begin
        state_q <= IDLE;
        idx_q   <= '0;
        cnt_q   <= '0;
        vec_q   <= '0;
        busy_q  <= 1'b0;
        pass_q  <= 1'b0;
      end else begin
        case (state_q)
          IDLE: begin
            if (start) begin
              tt_q    <= '0;
              mm_q    <= '0;
`ifdef TT_SWEEP_STABLE_CHECK_EN
              um_q    <= '0;
`endif
              pass_q  <= 1'b0;
              idx_q   <= '0;
              vec_q   <= '0;
              cnt_q   <= SETTLE_LOAD;
              busy_q  <= 1'b1;
              state_q <= SETTLE;
            end
          end
          SETTLE: begin
            cnt_q <= cnt_q - 8'd1;
            if (cnt_q == 8'd1) begin
              state_q <= SAMPLE;
`ifdef TT_SWEEP_STABLE_CHECK_EN
              stab_q  <= out_s;
`endif
            end
          end
          SAMPLE: begin
            tt_q <= tt_d;
`ifdef TT_SWEEP_STABLE_CHECK_EN
            um_q <= um_d;
`endif
            if (idx_q == 4'd15) begin
              state_q <= DONE;
              done_q  <= 1'b1;
              busy_q  <= 1'b0;
              vec_q   <= '0;
              mm_q    <= tt_d ^ EXPECTED_TT;
              pass_q  <= (tt_d == EXPECTED_TT) && (um_d == 16'h0000);
            end else begin
              idx_q   <= idx_q + 4'd1;
              vec_q   <= idx_q + 4'd1;
              cnt_q   <= SETTLE_LOAD;
              state_q <= SETTLE;
            end
          end
          DONE: begin
            idx_q   <= '0;
            state_q <= IDLE;
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign {in1, in2, in3, in4} = vec_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign pass          = pass_q;
  assign tt_captured   = tt_q;
  assign mismatch_mask = mm_q;
`ifdef TT_SWEEP_STABLE_CHECK_EN
  assign unstable_mask = um_q;
`else
  assign unstable_mask = '0;
`endif

endmodule

// File: tb/tb_tt_sweep_checker.sv
module tb_tt_sweep_checker;

  localparam int          SC     = 2;
  localparam int          P      = SC + 1;
  localparam int          SWEEP  = 16 * P;
  localparam logic [15:0] EXP_TT = 16'h2FC7;
`ifdef TT_SWEEP_STABLE_CHECK_EN
  localparam bit STAB = 1'b1;
`else
  localparam bit STAB = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n, start, abort, out_s;
  logic        in1, in2, in3, in4, busy, done, pass;
  logic [15:0] tt_captured, mismatch_mask, unstable_mask;

  logic [15:0] cut_tt;
  logic        glitch;
  int          cyc = 0;
  int          n_tests = 0;
  int          n_fail = 0;
  bit          trk_on = 1'b0;
  int          trk_base = 0;

  typedef struct {
    logic [15:0] tt;
    logic [15:0] mm;
    logic [15:0] um;
    logic        pass;
    int          done_cyc;
  } exp_t;
  exp_t exp_q[$];

  tt_sweep_checker #(.EXPECTED_TT(EXP_TT), .SETTLE_CYCLES(SC)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .out_s(out_s),
    .in1(in1), .in2(in2), .in3(in3), .in4(in4),
    .busy(busy), .done(done), .pass(pass),
    .tt_captured(tt_captured), .mismatch_mask(mismatch_mask),
    .unstable_mask(unstable_mask)
  );

  // circuit under test: a lookup of its truth table, optionally glitched
  assign out_s = cut_tt[{in1, in2, in3, in4}] ^ glitch;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // out_s level seen during sweep cycle k (k counted from the accepting edge)
  function automatic logic outv(input logic [15:0] cut, input int gk, input int k);
    return cut[4'(k / P)] ^ (k == gk);
  endfunction

  function automatic exp_t model(input logic [15:0] cut, input int gk, input int acc);
    exp_t e;
    logic s, l;
    e.tt = '0;
    e.um = '0;
    for (int v = 0; v < 16; v++) begin
      s = outv(cut, gk, v * P + SC);
      l = outv(cut, gk, v * P + SC - 1);
      e.tt[v] = s;
      e.um[v] = STAB && (s != l);
    end
    e.mm       = e.tt ^ EXP_TT;
    e.pass     = (e.mm == 16'h0000) && (e.um == 16'h0000);
    e.done_cyc = acc + SWEEP;
    return e;
  endfunction

  // monitor: scoreboard on done, plus per-cycle stimulus/busy timeline
  always @(negedge clk) begin
    exp_t e;
    int   k;
    if (rst_n) begin
      if (done) begin
        if (exp_q.size() == 0) begin
          chk("spurious_done", 32'(done), 32'(0));
        end else begin
          e = exp_q.pop_front();
          chk("done_cycle", 32'(cyc), 32'(e.done_cyc));
          chk("tt_captured", 32'(tt_captured), 32'(e.tt));
          chk("mismatch_mask", 32'(mismatch_mask), 32'(e.mm));
          chk("unstable_mask", 32'(unstable_mask), 32'(e.um));
          chk("pass", 32'(pass), 32'(e.pass));
        end
      end
      if (trk_on) begin
        k = cyc - trk_base;
        if (k <= SWEEP + 4) begin
          chk("busy_timeline", 32'(busy), 32'(k < SWEEP));
          chk("vector_timeline", 32'({in1, in2, in3, in4}), 32'((k < SWEEP) ? k / P : 0));
          chk("done_timeline", 32'(done), 32'(k == SWEEP));
        end
      end
    end
  end

  // Caller is #1 after an edge with the DUT idle.
  task automatic begin_sweep(input logic [15:0] cut, output int acc);
    cut_tt = cut;
    start  = 1'b1;
    @(posedge clk); #1;
    acc      = cyc;
    start    = 1'b0;
    trk_base = acc;
    trk_on   = 1'b1;
  endtask

  task automatic run_sweep(input logic [15:0] cut, input int gk, input int dup_k, input bit done_start);
    int acc;
    begin_sweep(cut, acc);
    exp_q.push_back(model(cut, gk, acc));
    for (int k = 0; k <= SWEEP + 4; k++) begin
      glitch = (k == gk);
      start  = (k == dup_k) || (done_start && (k == SWEEP));
      @(posedge clk); #1;
    end
    glitch = 1'b0;
    start  = 1'b0;
    trk_on = 1'b0;
  endtask

  task automatic run_abort(input logic [15:0] cut, input int ak);
    int          acc;
    logic [15:0] part;
    begin_sweep(cut, acc);
    part = '0;
    for (int v = 0; v < 16; v++) if (v * P + SC < ak) part[v] = cut[v];
    for (int k = 0; k < ak; k++) begin
      @(posedge clk); #1;
    end
    trk_on = 1'b0;
    abort  = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    chk("abort_busy", 32'(busy), 32'(0));
    chk("abort_vector", 32'({in1, in2, in3, in4}), 32'(0));
    chk("abort_pass", 32'(pass), 32'(0));
    chk("abort_done", 32'(done), 32'(0));
    chk("abort_tt_partial", 32'(tt_captured), 32'(part));
    repeat (SWEEP + 8) @(posedge clk);
    #1;
    chk("abort_busy_later", 32'(busy), 32'(0));
  endtask

  task automatic run_reset(input logic [15:0] cut, input int rk);
    int acc;
    begin_sweep(cut, acc);
    for (int k = 0; k < rk; k++) begin
      @(posedge clk); #1;
    end
    trk_on = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_busy", 32'(busy), 32'(0));
    chk("rst_done", 32'(done), 32'(0));
    chk("rst_pass", 32'(pass), 32'(0));
    chk("rst_vector", 32'({in1, in2, in3, in4}), 32'(0));
    chk("rst_tt", 32'(tt_captured), 32'(0));
    chk("rst_mm", 32'(mismatch_mask), 32'(0));
    chk("rst_um", 32'(unstable_mask), 32'(0));
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (SWEEP + 8) @(posedge clk);
    #1;
    chk("rst_busy_later", 32'(busy), 32'(0));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] cut;
    int          gk, dk;
    bit          ds;
    rst_n  = 1'b0;
    start  = 1'b0;
    abort  = 1'b0;
    glitch = 1'b0;
    cut_tt = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_busy", 32'(busy), 32'(0));
    chk("reset_done", 32'(done), 32'(0));
    chk("reset_pass", 32'(pass), 32'(0));
    chk("reset_vector", 32'({in1, in2, in3, in4}), 32'(0));
    chk("reset_tt", 32'(tt_captured), 32'(0));
    chk("reset_mm", 32'(mismatch_mask), 32'(0));
    chk("reset_um", 32'(unstable_mask), 32'(0));

    // start presented for the very first edge after reset release
    rst_n = 1'b1;
    run_sweep(EXP_TT, -1, -1, 1'b0);
    run_sweep(16'h0000, -1, -1, 1'b0);
    // repeated start mid-sweep and start during the DONE cycle
    run_sweep(EXP_TT, -1, 10, 1'b1);
    run_abort(EXP_TT, 5 * P + 1);
    run_abort(16'($urandom), 15 * P + SC);
    run_reset(EXP_TT, 9 * P + 1);
    run_sweep(16'($urandom), -1, -1, 1'b0);
    // output flips at sample of vector 3, in last settle of 7, in first settle of 4
    run_sweep(EXP_TT, 3 * P + SC, -1, 1'b0);
    run_sweep(EXP_TT, 7 * P + SC - 1, -1, 1'b0);
    run_sweep(EXP_TT, 4 * P, -1, 1'b0);

    for (int i = 0; i < 8; i++) begin
      cut = (i % 3 == 0) ? EXP_TT : 16'($urandom);
      gk  = int'($urandom_range(0, SWEEP)) - 1;
      dk  = int'($urandom_range(1, SWEEP - 1));
      ds  = 1'($urandom_range(0, 1));
      run_sweep(cut, gk, dk, ds);
    end

    chk("scoreboard_drained", 32'(exp_q.size()), 32'(0));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/tt_sweep_checker.md
TT_SWEEP_CHECKER -- requirements
Module: tt_sweep_checker

Interface
REQ-001 The block SHALL have parameter EXPECTED_TT, default 16'h2FC7: the expected 16-entry truth table, where bit i is the expected out for vector i.
REQ-002 The block SHALL have parameter SETTLE_CYCLES, default 8: the cycles each vector is held before out is sampled; legal range 1..255.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock, rising-edge active.
REQ-004 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-005 The block SHALL have port start, input, 1 bit: a one-cycle request to begin a sweep.
REQ-006 The block SHALL have port abort, input, 1 bit: terminates a sweep in progress.
REQ-007 The block SHALL have port out_s, input, 1 bit: the circuit output under test, already synchronous to clk.
REQ-008 The block SHALL have ports in1, in2, in3, in4, each output, 1 bit: the registered stimulus driven to the circuit under test.
REQ-009 The block SHALL have port busy, output, 1 bit: high while a sweep is active.
REQ-010 The block SHALL have port done, output, 1 bit: a one-cycle pulse when a sweep completes.
REQ-011 The block SHALL have port pass, output, 1 bit: high when the captured table equals EXPECTED_TT; held until the next accepted start.
REQ-012 The block SHALL have port tt_captured, output, 16 bits: the captured truth table.
REQ-013 The block SHALL have port mismatch_mask, output, 16 bits: tt_captured XOR EXPECTED_TT, valid when done pulses.
REQ-014 The block SHALL have port unstable_mask, output, 16 bits: flags vectors with unstable output (see Configuration).

Function
REQ-015 The block SHALL map vector index i[3:0] as in1=i[3], in2=i[2], in3=i[1], in4=i[0].
REQ-016 The state machine SHALL have states IDLE, SETTLE, SAMPLE and DONE.
REQ-017 In IDLE, start=1 SHALL clear tt_captured, mismatch_mask, unstable_mask and pass, set idx=0, drive vector 0, load the settle counter with SETTLE_CYCLES, set busy=1 and go to SETTLE.
REQ-018 SETTLE SHALL decrement the counter each cycle and go to SAMPLE in the cycle after the counter reaches 1.
REQ-019 SAMPLE SHALL write out_s into tt_captured[idx].
REQ-020 From SAMPLE with idx<15, the block SHALL increment idx, drive the new vector, reload the counter and return to SETTLE.
REQ-021 From SAMPLE with idx=15, the block SHALL go to DONE.
REQ-022 Each vector SHALL occupy exactly SETTLE_CYCLES+1 cycles.
REQ-023 The done pulse SHALL occur exactly 16*(SETTLE_CYCLES+1) cycles after the edge that accepted start.
REQ-024 DONE SHALL last one cycle: done=1, mismatch_mask and pass updated, busy=0, in1..in4 driven to 0, then return to IDLE.
REQ-025 start while busy=1 or in DONE SHALL be ignored.
REQ-026 abort=1 in any non-IDLE state SHALL return the block to IDLE on the next edge with busy=0, in1..in4=0 and pass=0, and done SHALL NOT pulse.
REQ-027 abort SHALL take priority over a simultaneous SAMPLE-to-DONE transition.
REQ-028 tt_captured bits not yet sampled SHALL read 0.
REQ-029 idx SHALL NOT wrap: after sample 15, no further stimulus change SHALL occur until the next start.

Reset
REQ-030 rst_n=0 SHALL immediately force state IDLE, idx=0, counter=0, in1..in4=0, busy=0, done=0, pass=0, and tt_captured, mismatch_mask and unstable_mask all to 0.
REQ-031 Reset asserted mid-sweep SHALL discard the sweep, and no done pulse SHALL follow reset release.
REQ-032 The first start SHALL be accepted on the first rising edge after rst_n deasserts.

Configuration
REQ-033 The macro TT_SWEEP_STABLE_CHECK_EN SHALL control the stability check.
REQ-034 When TT_SWEEP_STABLE_CHECK_EN is defined, out_s SHALL be registered during the last settle cycle; if that value differs from out_s at SAMPLE, unstable_mask[idx] SHALL be set to 1 and pass SHALL be forced to 0 at DONE.
REQ-035 When TT_SWEEP_STABLE_CHECK_EN is undefined, unstable_mask SHALL be tied to 0, no extra flop SHALL exist, and pass SHALL depend only on mismatch_mask.

Verification
REQ-036 With SETTLE_CYCLES=2 and out_s from a correct behavioural model of 0x2FC7, start -> done at cycle 48, tt_captured=16'h2FC7, mismatch_mask=0, pass=1.
REQ-037 With out_s stuck at 0, a full sweep -> tt_captured=16'h0000, mismatch_mask=16'h2FC7, pass=0.
REQ-038 A second start pulsed at cycle 10 of a sweep -> ignored, and done still occurs at cycle 48 with one pulse only.
REQ-039 abort at idx=5 -> next cycle busy=0, in1..in4=0, no done pulse, tt_captured bits 5..15 equal 0.
REQ-040 rst_n pulsed low at idx=9 -> all outputs 0 asynchronously, and a subsequent start runs a clean 48-cycle sweep.
REQ-041 With TT_SWEEP_STABLE_CHECK_EN defined and out_s toggling between the last settle cycle and SAMPLE of vector 3 -> unstable_mask=16'h0008, pass=0.
